flash_arbiter: RTL and testbench
================================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter READ_CMD, default 8'h03, meaning the SPI read opcode sent first in every transaction.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cpu_req_valid  input  1, cpu_req_addr  input  24, cpu_req_ready  output  1: CPU read request and handshake.
REQ-005 SHALL have ports cpu_rsp_valid  output  1, cpu_rsp_data  output  32: CPU read response.
REQ-006 SHALL have ports dma_req_valid  input  1, dma_req_addr  input  24, dma_req_ready  output  1, dma_rsp_valid  output  1, dma_rsp_data  output  32: same set for the DMA/IPL loader requester.
REQ-007 SHALL have ports flash_sck  output  1, flash_csn  output  1, flash_mosi  output  1, flash_miso  input  1: SPI flash pins.
REQ-008 SHALL have port busy  output  1, high in every state except IDLE.

Function
REQ-009 SHALL implement states IDLE -> SHIFT -> DONE -> IDLE.
REQ-010 In IDLE, a request SHALL be accepted in cycle T where req_valid && req_ready; ready SHALL be high only in IDLE, for the granted requester only.
REQ-011 When exactly one valid is high, that requester SHALL be granted; when both are high, the requester not granted in the previous transaction SHALL be granted; the first grant after reset SHALL go to CPU.
REQ-012 The address SHALL be latched at acceptance; the requester may change or drop req_addr and req_valid afterwards.
REQ-013 SHIFT SHALL send 64 bits MSB-first: READ_CMD[7:0], addr[23:0], then 32 dummy bits (mosi 0) while receiving data.
REQ-014 SPI SHALL be mode 0: sck idle low, half period one clk; bit i (0..63) driven on mosi in cycle T+1+2i with sck low, sck high in cycle T+2+2i, miso registered at the end of cycle T+2+2i.
REQ-015 flash_csn SHALL be low from cycle T+1 through T+128 inclusive, and high otherwise.
REQ-016 Received bytes SHALL be assembled little-endian: the byte from addr in rsp_data[7:0], from addr+3 in rsp_data[31:24].
REQ-017 In DONE (cycle T+129), rsp_valid of the granted requester SHALL pulse high for exactly one cycle with rsp_data valid; IDLE SHALL resume at T+130.
REQ-018 rsp_data SHALL hold its value until the next response to the same requester.
REQ-019 A request arriving during SHIFT/DONE SHALL wait with ready low; no request is dropped, reordered or duplicated.
REQ-020 Address 24'hFFFFFD..FFFFFF SHALL be issued unchanged; wrap past 24'hFFFFFF is the flash's behaviour, not this block's.
REQ-021 The other requester's rsp_valid SHALL stay low throughout a transaction.

Reset
REQ-022 Reset SHALL force, from the next cycle: state IDLE, flash_csn 1, flash_sck 0, flash_mosi 0, both ready 0 during reset, both rsp_valid 0, rsp_data 32'h0, busy 0, last-grant = DMA (so CPU wins first).
REQ-023 Reset asserted mid-transaction SHALL abort it with no rsp_valid pulse; csn SHALL go high in the cycle after reset is sampled.

Structure
REQ-024 A shared package ics32_flash_pkg SHALL hold the state enum, FLASH_ADDR_W = 24, FLASH_DATA_W = 32, TXN_BITS = 64 and the default read opcode.
REQ-025 The bit engine (csn/sck/mosi sequencing, 6-bit bit counter, 32-bit receive shift register) SHALL be one sub-module, flash_spi_shifter; arbitration and response routing stay in flash_arbiter.

Verification
REQ-026 CPU reads addr 24'h000100 with flash bytes 11,22,33,44 -> mosi stream 03 00 01 00; cpu_rsp_valid at T+129; cpu_rsp_data 32'h44332211.
REQ-027 CPU and DMA valid in the same cycle after reset -> CPU granted first, DMA accepted at the first IDLE after; responses in that order, each a single pulse.
REQ-028 Both held valid for 4 transactions -> grants alternate CPU, DMA, CPU, DMA.
REQ-029 Reset pulsed at T+40 of a DMA read -> csn high at T+42; no dma_rsp_valid; next CPU read is correct.
REQ-030 Back-to-back DMA reads -> csn high for at least 2 cycles between transactions; count exactly 64 sck rising edges per csn-low window.

Source files
------------

// File: rtl/ics32_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ics32_flash_pkg
// Description : Shared types and constants for the SPI flash read path:
//               controller state encoding, address/data/transaction widths,
//               default read opcode and a byte-swap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ics32_flash_pkg;

  localparam int         FLASH_ADDR_W   = 24;
  localparam int         FLASH_DATA_W   = 32;
  localparam int         TXN_BITS       = 64;
  localparam logic [7:0] FLASH_READ_CMD = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } flash_state_e;

  // The flash streams bytes in address order, first byte ending up in the
  // top of the shift register; requesters want the lowest address in [7:0].
  function automatic logic [FLASH_DATA_W-1:0] flash_bswap32(
    input logic [FLASH_DATA_W-1:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : flash_spi_shifter
// Description : SPI mode-0 bit engine for one 64-bit flash read: opcode,
//               24-bit address, then 32 dummy bits while shifting in data.
//               sck half period is one clk; csn is low for 128 cycles.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start, addr     - begin a transaction with this address
//               done            - high in the last sck-high cycle
//               rx_word         - last 32 bits received, MSB first-in
//               flash_sck/csn/mosi, flash_miso - SPI pins
// Revision    : 1.0 - initial release
// ============================================================================
module flash_spi_shifter
  import ics32_flash_pkg::*;
#(
  parameter logic [7:0] READ_CMD = FLASH_READ_CMD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FLASH_ADDR_W-1:0] addr,
  output logic                    done,
  output logic [FLASH_DATA_W-1:0] rx_word,
  output logic                    flash_sck,
  output logic                    flash_csn,
  output logic                    flash_mosi,
  input  logic                    flash_miso
);

  logic [5:0]              bit_cnt;
  logic [31:0]             tx_q;
  logic [FLASH_DATA_W-1:0] rx_q;
  logic                    last_bit;

  // csn low doubles as the "active" flag and sck as the half-period phase.
  assign last_bit = !flash_csn && flash_sck && (bit_cnt == 6'(TXN_BITS - 1));
  assign done     = last_bit;
  assign rx_word  = rx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_csn  <= 1'b1;
      flash_sck  <= 1'b0;
      flash_mosi <= 1'b0;
      bit_cnt    <= 6'd0;
      tx_q       <= 32'd0;
      rx_q       <= '0;
    end else if (start && flash_csn) begin
      // Bit 0 goes out immediately; tx_q holds the remaining 31 header bits
      // and zero-fills behind them, which yields the dummy bits for free.
      flash_csn  <= 1'b0;
      flash_sck  <= 1'b0;
      flash_mosi <= READ_CMD[7];
      tx_q       <= {READ_CMD[6:0], addr, 1'b0};
      bit_cnt    <= 6'd0;
    end else if (!flash_csn) begin
      if (!flash_sck) begin
        flash_sck <= 1'b1;
      end else begin
        rx_q      <= {rx_q[FLASH_DATA_W-2:0], flash_miso};
        flash_sck <= 1'b0;
        if (last_bit) begin
          flash_csn  <= 1'b1;
          flash_mosi <= 1'b0;
        end else begin
          bit_cnt    <= bit_cnt + 6'd1;
          flash_mosi <= tx_q[31];
          tx_q       <= {tx_q[30:0], 1'b0};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flash_arbiter
// Description : Arbitrates CPU and DMA read requests onto one SPI flash.
//               Alternating priority on contention (CPU first after reset),
//               one 64-bit SPI read per request, per-requester response regs.
// Ports       : clk, reset                      - clock, sync active-high reset
//               cpu_req_valid/addr/ready         - CPU request handshake
//               cpu_rsp_valid/data               - CPU response
//               dma_req_* / dma_rsp_*            - same for DMA requester
//               flash_sck/csn/mosi, flash_miso   - SPI flash pins
//               busy                             - high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module flash_arbiter
  import ics32_flash_pkg::*;
#(
  parameter logic [7:0] READ_CMD = FLASH_READ_CMD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req_valid,
  input  logic [FLASH_ADDR_W-1:0] cpu_req_addr,
  output logic                    cpu_req_ready,
  output logic                    cpu_rsp_valid,
  output logic [FLASH_DATA_W-1:0] cpu_rsp_data,
  input  logic                    dma_req_valid,
  input  logic [FLASH_ADDR_W-1:0] dma_req_addr,
  output logic                    dma_req_ready,
  output logic                    dma_rsp_valid,
  output logic [FLASH_DATA_W-1:0] dma_rsp_data,
  output logic                    flash_sck,
  output logic                    flash_csn,
  output logic                    flash_mosi,
  input  logic                    flash_miso,
  output logic                    busy
);

  flash_state_e            state, state_next;
  logic                    last_dma;   // previous grant went to DMA
  logic                    cur_dma;    // owner of the transaction in flight
  logic                    pick_dma;
  logic                    accept;
  logic                    shift_done;
  logic [FLASH_ADDR_W-1:0] start_addr;
  logic [FLASH_DATA_W-1:0] rx_word;
  logic [FLASH_DATA_W-1:0] rsp_word;
  logic [FLASH_DATA_W-1:0] cpu_rsp_q;
  logic [FLASH_DATA_W-1:0] dma_rsp_q;

  // DMA wins only when it is the sole requester or CPU had the last turn.
  assign pick_dma      = dma_req_valid && (!cpu_req_valid || !last_dma);
  assign cpu_req_ready = (state == ST_IDLE) && !reset && cpu_req_valid && !pick_dma;
  assign dma_req_ready = (state == ST_IDLE) && !reset && pick_dma;
  assign accept        = cpu_req_ready || dma_req_ready;
  assign start_addr    = pick_dma ? dma_req_addr : cpu_req_addr;

  assign rsp_word      = flash_bswap32(rx_word);
  assign cpu_rsp_valid = (state == ST_DONE) && !cur_dma;
  assign dma_rsp_valid = (state == ST_DONE) && cur_dma;
  // The held registers are only updated at the end of DONE, so the live
  // word is muxed through during the pulse itself.
  assign cpu_rsp_data  = cpu_rsp_valid ? rsp_word : cpu_rsp_q;
  assign dma_rsp_data  = dma_rsp_valid ? rsp_word : dma_rsp_q;
  assign busy          = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept)     state_next = ST_SHIFT;
      ST_SHIFT: if (shift_done) state_next = ST_DONE;
      ST_DONE:                  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      last_dma  <= 1'b1;
      cur_dma   <= 1'b0;
      cpu_rsp_q <= '0;
      dma_rsp_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_dma <= pick_dma;
        cur_dma  <= pick_dma;
      end
      if (state == ST_DONE) begin
        if (cur_dma) dma_rsp_q <= rsp_word;
        else         cpu_rsp_q <= rsp_word;
      end
    end
  end

  flash_spi_shifter #(
    .READ_CMD (READ_CMD)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .start      (accept),
    .addr       (start_addr),
    .done       (shift_done),
    .rx_word    (rx_word),
    .flash_sck  (flash_sck),
    .flash_csn  (flash_csn),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso)
  );

endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_arbiter
// Description : Self-checking bench for flash_arbiter with a behavioural SPI
//               flash model, arbitration model and response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req_valid = 1'b0, dma_req_valid = 1'b0;
  logic [23:0] cpu_req_addr = 24'd0, dma_req_addr = 24'd0;
  logic        cpu_req_ready, dma_req_ready, cpu_rsp_valid, dma_rsp_valid;
  logic [31:0] cpu_rsp_data, dma_rsp_data;
  logic        flash_sck, flash_csn, flash_mosi, busy;
  logic        flash_miso = 1'b0;

  always #5 clk = ~clk;

  flash_arbiter #(.READ_CMD(8'h03)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .dma_req_valid(dma_req_valid), .dma_req_addr(dma_req_addr), .dma_req_ready(dma_req_ready),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
    .flash_sck(flash_sck), .flash_csn(flash_csn), .flash_mosi(flash_mosi),
    .flash_miso(flash_miso), .busy(busy)
  );

  typedef struct { int cyc; bit is_dma; bit exp_dma; logic [23:0] addr; } grant_t;
  typedef struct { int cyc; bit is_dma; logic [31:0] data; } rsp_t;
  typedef struct { int start; int len; int rises; logic [31:0] hdr; int dummy_err; int gap; } win_t;

  grant_t      grants[$];
  rsp_t        rsps[$];
  win_t        wins[$];
  logic [23:0] cpu_pend[$], dma_pend[$];

  int   cyc = 0;
  int   total = 0, bad = 0;
  int   viol = 0;
  int   exp_busy_until = -1;
  bit   model_last_dma = 1'b1;
  bit   cpu_hs = 1'b0, dma_hs = 1'b0;
  bit   in_win = 1'b0;
  logic prev_sck = 1'b0;
  int   high_run = 0;
  win_t w;
  logic [31:0] last_cpu_exp = 32'd0, last_dma_exp = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents: four fixed bytes at 0x100 plus an address hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a >= 24'h000100 && a <= 24'h000103) return 8'(8'h11 * (a - 24'h0000FF));
    return 8'((a * 24'd7) ^ (a >> 9) ^ 24'h5A);
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle observer: handshakes, arbitration model, busy/ready rules,
  // responses and the SPI flash device itself.
  always @(negedge clk) begin
    int b, k;
    logic [7:0] byte_v;
    grant_t g;
    rsp_t r;
    cpu_hs = cpu_req_valid && cpu_req_ready;
    dma_hs = dma_req_valid && dma_req_ready;
    if (reset) begin
      exp_busy_until = -1;
      model_last_dma = 1'b1;
      if (cpu_req_ready || dma_req_ready) viol++;
    end else begin
      if (busy !== (cyc <= exp_busy_until)) viol++;
      if ((cpu_req_ready || dma_req_ready) && cyc <= exp_busy_until) viol++;
      if (cpu_hs && dma_hs) viol++;
      if (cyc > exp_busy_until && (cpu_req_valid || dma_req_valid) && !(cpu_hs || dma_hs)) viol++;
      if (cpu_hs || dma_hs) begin
        g.cyc     = cyc;
        g.is_dma  = dma_hs;
        g.exp_dma = dma_req_valid && (!cpu_req_valid || !model_last_dma);
        g.addr    = dma_hs ? dma_req_addr : cpu_req_addr;
        grants.push_back(g);
        model_last_dma = g.exp_dma;
        exp_busy_until = cyc + 129;
      end
    end
    if (cpu_rsp_valid) begin r.cyc = cyc; r.is_dma = 1'b0; r.data = cpu_rsp_data; rsps.push_back(r); end
    if (dma_rsp_valid) begin r.cyc = cyc; r.is_dma = 1'b1; r.data = dma_rsp_data; rsps.push_back(r); end

    if (flash_csn === 1'b0) begin
      if (!in_win) begin
        in_win = 1'b1;
        w.start = cyc; w.len = 0; w.rises = 0; w.hdr = 32'd0; w.dummy_err = 0; w.gap = high_run;
      end
      w.len++;
      if (flash_sck === 1'b1 && prev_sck !== 1'b1) begin
        b = w.rises;
        w.rises++;
        if (b < 32) begin
          w.hdr = {w.hdr[30:0], flash_mosi};
          flash_miso = 1'($urandom_range(0, 1));
        end else begin
          if (flash_mosi !== 1'b0) w.dummy_err++;
          k = (b - 32) / 8;
          byte_v = mem_byte(w.hdr[23:0] + 24'(k));
          flash_miso = byte_v[7 - ((b - 32) % 8)];
        end
      end else begin
        flash_miso = 1'($urandom_range(0, 1));
      end
    end else begin
      if (in_win) begin in_win = 1'b0; wins.push_back(w); high_run = 0; end
      high_run++;
      if (flash_sck === 1'b1 && !reset) viol++;
    end
    prev_sck = flash_sck;
  end

  task automatic run_traffic(input int gap_pct, input int max_cycles);
    int n = 0;
    while ((cpu_pend.size() != 0 || dma_pend.size() != 0 || busy === 1'b1) && n < max_cycles) begin
      @(posedge clk); #1; n++;
      if (cpu_hs) void'(cpu_pend.pop_front());
      if (dma_hs) void'(dma_pend.pop_front());
      if (!(cpu_req_valid && !cpu_hs)) begin
        if (cpu_pend.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
          cpu_req_valid = 1'b1; cpu_req_addr = cpu_pend[0];
        end else begin
          cpu_req_valid = 1'b0; cpu_req_addr = 24'($urandom);
        end
      end
      if (!(dma_req_valid && !dma_hs)) begin
        if (dma_pend.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
          dma_req_valid = 1'b1; dma_req_addr = dma_pend[0];
        end else begin
          dma_req_valid = 1'b0; dma_req_addr = 24'($urandom);
        end
      end
    end
    chk("traffic_budget", 64'(n < max_cycles), 64'd1);
    cpu_req_valid = 1'b0;
    dma_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    grant_t g;
    rsp_t   r;
    win_t   v;
    chk($sformatf("%s_nrsp", tag), 64'(rsps.size()), 64'(grants.size()));
    chk($sformatf("%s_nwin", tag), 64'(wins.size()), 64'(grants.size()));
    for (int i = 0; i < grants.size(); i++) begin
      g = grants[i];
      chk($sformatf("%s_arb%0d", tag, i), 64'(g.is_dma), 64'(g.exp_dma));
      if (i < rsps.size()) begin
        r = rsps[i];
        chk($sformatf("%s_who%0d", tag, i), 64'(r.is_dma), 64'(g.is_dma));
        chk($sformatf("%s_rcyc%0d", tag, i), 64'(r.cyc), 64'(g.cyc + 129));
        chk($sformatf("%s_data%0d", tag, i), 64'(r.data), 64'(exp_word(g.addr)));
        if (g.is_dma) last_dma_exp = exp_word(g.addr);
        else          last_cpu_exp = exp_word(g.addr);
      end
      if (i < wins.size()) begin
        v = wins[i];
        chk($sformatf("%s_csn_start%0d", tag, i), 64'(v.start), 64'(g.cyc + 1));
        chk($sformatf("%s_csn_len%0d", tag, i), 64'(v.len), 64'd128);
        chk($sformatf("%s_sck%0d", tag, i), 64'(v.rises), 64'd64);
        chk($sformatf("%s_hdr%0d", tag, i), 64'(v.hdr), 64'({8'h03, g.addr}));
        chk($sformatf("%s_dummy%0d", tag, i), 64'(v.dummy_err), 64'd0);
        chk($sformatf("%s_gap%0d", tag, i), 64'(v.gap >= 2), 64'd1);
      end
    end
    chk($sformatf("%s_viol", tag), 64'(viol), 64'd0);
    chk($sformatf("%s_cpu_hold", tag), 64'(cpu_rsp_data), 64'(last_cpu_exp));
    chk($sformatf("%s_dma_hold", tag), 64'(dma_rsp_data), 64'(last_dma_exp));
    grants.delete(); rsps.delete(); wins.delete(); viol = 0;
  endtask

  initial begin
    logic [31:0] d0;
    logic [3:0]  ord;
    int          t0;
    int          n;

    // Reset with a CPU request pending: ready must stay low throughout.
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 24'h000100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csn", 64'(flash_csn), 64'd1);
    chk("rst_sck", 64'(flash_sck), 64'd0);
    chk("rst_mosi", 64'(flash_mosi), 64'd0);
    chk("rst_cpu_ready", 64'(cpu_req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'({cpu_rsp_valid, dma_rsp_valid}), 64'd0);
    chk("rst_cpu_data", 64'(cpu_rsp_data), 64'd0);
    chk("rst_dma_data", 64'(dma_rsp_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_req_valid = 1'b0;
    grants.delete(); rsps.delete(); wins.delete(); viol = 0;

    // Simultaneous CPU/DMA after reset; CPU reads the known bytes at 0x100.
    cpu_pend.push_back(24'h000100);
    dma_pend.push_back(24'h000200);
    run_traffic(0, 600);
    d0 = (rsps.size() > 0) ? rsps[0].data : 32'hx;
    chk("cpu_0x100_data", 64'(d0), 64'h44332211);
    d0 = (wins.size() > 0) ? wins[0].hdr : 32'hx;
    chk("cpu_0x100_mosi", 64'(d0), 64'h03000100);
    t0 = (grants.size() > 1) ? grants[1].cyc - grants[0].cyc : -1;
    chk("dma_next_idle", 64'(t0), 64'd130);
    check_all("first");

    // Both held valid for four transactions: strict alternation.
    cpu_pend.push_back(24'($urandom)); cpu_pend.push_back(24'($urandom));
    dma_pend.push_back(24'($urandom)); dma_pend.push_back(24'($urandom));
    run_traffic(0, 1200);
    ord = 4'b1111;
    for (int i = 0; i < 4 && i < grants.size(); i++) ord[3 - i] = grants[i].is_dma;
    chk("alternate", 64'(ord), 64'b0101);
    check_all("alt");

    // Top-of-range addresses go out unchanged.
    cpu_pend.push_back(24'hFFFFFD); cpu_pend.push_back(24'hFFFFFF);
    dma_pend.push_back(24'hFFFFFE);
    run_traffic(0, 900);
    check_all("edge");

    // Randomized traffic with random request gaps.
    for (int i = 0; i < 6; i++) begin
      cpu_pend.push_back(24'($urandom));
      dma_pend.push_back(24'($urandom));
    end
    run_traffic(40, 4000);
    check_all("rand");

    // Back-to-back DMA only.
    for (int i = 0; i < 3; i++) dma_pend.push_back(24'($urandom));
    run_traffic(0, 900);
    check_all("b2b");

    // Reset in the middle of a DMA read.
    dma_req_valid = 1'b1;
    dma_req_addr  = 24'h00ABCD;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dma_hs && n < 20);
    dma_req_valid = 1'b0;
    chk("abort_grant", 64'(grants.size()), 64'd1);
    t0 = (grants.size() > 0) ? grants[0].cyc : cyc;
    while (cyc < t0 + 40) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_cpu_exp = 32'd0;
    last_dma_exp = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_cyc", 64'(cyc), 64'(t0 + 42));
    chk("abort_csn", 64'(flash_csn), 64'd1);
    repeat (200) @(negedge clk);
    chk("abort_no_rsp", 64'(rsps.size()), 64'd0);
    chk("abort_viol", 64'(viol), 64'd0);
    chk("abort_cpu_data", 64'(cpu_rsp_data), 64'd0);
    chk("abort_dma_data", 64'(dma_rsp_data), 64'd0);
    grants.delete(); rsps.delete(); wins.delete(); viol = 0;
    @(posedge clk); #1;
    cpu_pend.push_back(24'h000100);
    run_traffic(0, 600);
    d0 = (rsps.size() > 0) ? rsps[0].data : 32'hx;
    chk("post_abort_data", 64'(d0), 64'h44332211);
    check_all("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
